// File: rtl/hw_status_pkg.sv
// hw_status_pkg: shared definitions for the hardware-manager status word.
//
// Layout of status_word (32 bits):
//   [31:29] board_num   (3 bits)
//   [28:4]  status_code (25 bits)
//   [3:0]   state       (4 bits)
//
// Contents: state encodings, status codes, field positions/widths and
// small field-extraction helpers used by hw_status_logger.
package hw_status_pkg;

    localparam int STATUS_W  = 32;

    localparam int BOARD_LSB = 29;
    localparam int BOARD_W   = 3;
    localparam int CODE_LSB  = 4;
    localparam int CODE_W    = 25;
    localparam int STATE_LSB = 0;
    localparam int STATE_W   = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 4'd1,
        ST_INIT    = 4'd2,
        ST_CONFIG  = 4'd3,
        ST_ARMED   = 4'd4,
        ST_RUNNING = 4'd5,
        ST_ERROR   = 4'd6,
        ST_HALTED  = 4'd7
    } hw_state_e;

    typedef enum logic [CODE_W-1:0] {
        CODE_OK            = 25'd1,
        CODE_BOOT          = 25'd2,
        CODE_CFG_LOAD      = 25'd3,
        CODE_CFG_DONE      = 25'd4,
        CODE_CLK_LOCK      = 25'd5,
        CODE_CLK_LOST      = 25'd6,
        CODE_PWR_GOOD      = 25'd7,
        CODE_PWR_FAIL      = 25'd8,
        CODE_TEMP_WARN     = 25'd9,
        CODE_TEMP_CRIT     = 25'd10,
        CODE_LINK_UP       = 25'd11,
        CODE_LINK_DOWN     = 25'd12,
        CODE_DMA_START     = 25'd13,
        CODE_DMA_DONE      = 25'd14,
        CODE_DMA_ERR       = 25'd15,
        CODE_FIFO_OVF      = 25'd16,
        CODE_FIFO_UNF      = 25'd17,
        CODE_CRC_ERR       = 25'd18,
        CODE_TIMEOUT       = 25'd19,
        CODE_CMD_BAD       = 25'd20,
        CODE_CMD_DONE      = 25'd21,
        CODE_SHUTDOWN_REQ  = 25'd22,
        CODE_SHUTDOWN_DONE = 25'd23
    } hw_code_e;

    function automatic logic [STATE_W-1:0] field_state(input logic [STATUS_W-1:0] w);
        return w[STATE_LSB +: STATE_W];
    endfunction

    function automatic logic [CODE_W-1:0] field_code(input logic [STATUS_W-1:0] w);
        return w[CODE_LSB +: CODE_W];
    endfunction

    function automatic logic [BOARD_W-1:0] field_board(input logic [STATUS_W-1:0] w);
        return w[BOARD_LSB +: BOARD_W];
    endfunction

endpackage

// File: rtl/status_fifo.sv
// status_fifo: synchronous first-word-fall-through FIFO.
//
// Ports:
//   clk, n_rst   clock, asynchronous active-low reset (empties FIFO, zeroes storage)
//   push, wdata  write request and data; accepted when not full, or when
//                full and a valid pop happens in the same cycle
//   pop          read strobe; ignored when empty
//   rdata        head entry, combinational from registered storage
//   full, empty  occupancy flags, derived from count
//   count        entries held, 0..DEPTH
//
// Handshake: an entry is written on a clk edge where push is high and the
// FIFO can accept; the head is removed on a clk edge where pop is high and
// the FIFO is non-empty. Neither strobe has any effect otherwise.
module status_fifo
    import hw_status_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + PTR_ONE;
            end
            if (pop_ok) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hw_status_logger.sv
// hw_status_logger: captures timestamped snapshots of the hardware manager's
// status word on each rising edge of ps_interrupt, queues them in a FWFT
// FIFO for the PS, and raises a level interrupt until acknowledged.
//
// Ports:
//   clk, n_rst     clock, asynchronous active-low reset
//   status_word    status from hardware manager ({board, code, state})
//   ps_interrupt   event source; its rising edge is the event
//   log_pop        PS read strobe, removes head entry (ignored when empty)
//   irq_ack        PS interrupt acknowledge
//   ovf_clr        clears overflow and drop_count
//   log_valid      FIFO non-empty
//   log_status     head entry status word
//   log_time       head entry timestamp
//   log_count      entries held
//   irq_out        level interrupt to PS
//   overflow       sticky drop flag
//   drop_count     saturating count of dropped events
//   cur_state/cur_code/cur_board  registered fields of status_word
//   halted         cur_state == HALTED_STATE
//
// Optional build macro HW_STATUS_LOGGER_DEDUP_EN: when defined, an event
// whose status word equals the last accepted one is ignored entirely.
module hw_status_logger
    import hw_status_pkg::*;
#(
    parameter int                   DEPTH        = 16,
    parameter int                   TS_WIDTH     = 32,
    parameter logic [STATE_W-1:0]   HALTED_STATE = 4'd7
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [STATUS_W-1:0]      status_word,
    input  logic                     ps_interrupt,
    input  logic                     log_pop,
    input  logic                     irq_ack,
    input  logic                     ovf_clr,
    output logic                     log_valid,
    output logic [STATUS_W-1:0]      log_status,
    output logic [TS_WIDTH-1:0]      log_time,
    output logic [$clog2(DEPTH):0]   log_count,
    output logic                     irq_out,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    output logic [STATE_W-1:0]       cur_state,
    output logic [CODE_W-1:0]        cur_code,
    output logic [BOARD_W-1:0]       cur_board,
    output logic                     halted
);

    localparam int EW = STATUS_W + TS_WIDTH;
    localparam logic [TS_WIDTH-1:0] TS_ONE = TS_WIDTH'(1);

    logic                  ps_q;
    logic [TS_WIDTH-1:0]   ts;
    logic [STATUS_W-1:0]   cur_word;
    logic                  ev;
    logic                  ev_eff;
    logic                  drop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [EW-1:0]         fifo_rdata;

    assign ev = ps_interrupt & ~ps_q;

`ifdef HW_STATUS_LOGGER_DEDUP_EN
    logic [STATUS_W-1:0]   last_word;
    logic                  last_valid;
    logic                  accept;

    assign ev_eff = ev & ~(last_valid && (status_word == last_word));
    assign accept = ev_eff & (~fifo_full | (log_pop & ~fifo_empty));

    // Only entries actually written update the comparison word; a drop
    // leaves it alone so the same status can still be logged later.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            last_word  <= '0;
            last_valid <= 1'b0;
        end else if (accept) begin
            last_word  <= status_word;
            last_valid <= 1'b1;
        end else if (ovf_clr) begin
            last_valid <= 1'b0;
        end
    end
`else
    assign ev_eff = ev;
`endif

    // Full implies non-empty, so a pop in the same cycle always frees a slot.
    assign drop = ev_eff & fifo_full & ~log_pop;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ps_q     <= 1'b0;
            ts       <= '0;
            cur_word <= '0;
        end else begin
            ps_q     <= ps_interrupt;
            ts       <= ts + TS_ONE;
            cur_word <= status_word;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            irq_out <= 1'b0;
        end else if (ev_eff) begin
            irq_out <= 1'b1;
        end else if (irq_ack) begin
            irq_out <= 1'b0;
        end
    end

    // A drop coincident with ovf_clr restarts the count at one.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (ovf_clr) begin
                drop_count <= 8'd1;
            end else if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end else if (ovf_clr) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    status_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (ev_eff),
        .pop   (log_pop),
        .wdata ({status_word, ts}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (log_count)
    );

    assign log_valid  = ~fifo_empty;
    assign log_status = fifo_rdata[TS_WIDTH +: STATUS_W];
    assign log_time   = fifo_rdata[TS_WIDTH-1:0];

    assign cur_state  = field_state(cur_word);
    assign cur_code   = field_code(cur_word);
    assign cur_board  = field_board(cur_word);
    assign halted     = (cur_state == HALTED_STATE);

endmodule

// File: tb/tb_hw_status_logger.sv
// tb_hw_status_logger: directed bench for hw_status_logger (DEPTH=16,
// TS_WIDTH=32). Inputs change on the falling edge; outputs are sampled on
// the falling edge. Expected log entries {status, timestamp} are queued when
// an event is driven and compared as the bench pops them.
module tb_hw_status_logger;

    localparam int DEPTH = 16;
    localparam int TS_W  = 32;
    localparam int EW    = 32 + TS_W;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [31:0] status_word;
    logic        ps_interrupt;
    logic        log_pop;
    logic        irq_ack;
    logic        ovf_clr;
    logic        log_valid;
    logic [31:0] log_status;
    logic [TS_W-1:0] log_time;
    logic [4:0]  log_count;
    logic        irq_out;
    logic        overflow;
    logic [7:0]  drop_count;
    logic [3:0]  cur_state;
    logic [24:0] cur_code;
    logic [2:0]  cur_board;
    logic        halted;

    logic [EW-1:0] exp_q[$];
    logic [31:0]   tb_ts;
    int            checks = 0;
    int            errors = 0;

    hw_status_logger #(.DEPTH(DEPTH), .TS_WIDTH(TS_W), .HALTED_STATE(4'd7)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .status_word  (status_word),
        .ps_interrupt (ps_interrupt),
        .log_pop      (log_pop),
        .irq_ack      (irq_ack),
        .ovf_clr      (ovf_clr),
        .log_valid    (log_valid),
        .log_status   (log_status),
        .log_time     (log_time),
        .log_count    (log_count),
        .irq_out      (irq_out),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .cur_state    (cur_state),
        .cur_code     (cur_code),
        .cur_board    (cur_board),
        .halted       (halted)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // Reference timestamp: cycles since reset release.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) tb_ts <= '0;
        else        tb_ts <= tb_ts + 32'd1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle event pulse followed by one low cycle.
    task automatic send_ev(input logic [31:0] w, input bit exp_push);
        status_word  = w;
        ps_interrupt = 1'b1;
        if (exp_push) exp_q.push_back({w, tb_ts});
        @(negedge clk);
        ps_interrupt = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_one(input string tag);
        logic [EW-1:0] e;
        check({tag, "_valid"}, EW'(log_valid), EW'(1));
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed pop request, required expected-queue entry", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, {log_status, log_time}, e);
        end
        log_pop = 1'b1;
        @(negedge clk);
        log_pop = 1'b0;
    endtask

    task automatic pulse(input int which);
        if (which == 0) irq_ack = 1'b1; else ovf_clr = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        ovf_clr = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        logic [TS_W-1:0] last_t;
        int guard;

        n_rst        = 1'b0;
        status_word  = 32'h0000_0016;
        ps_interrupt = 1'b0;
        log_pop      = 1'b0;
        irq_ack      = 1'b0;
        ovf_clr      = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_valid",  EW'(log_valid),  EW'(0));
        check("rst_count",  EW'(log_count),  EW'(0));
        check("rst_status", EW'(log_status), EW'(0));
        check("rst_time",   EW'(log_time),   EW'(0));
        check("rst_irq",    EW'(irq_out),    EW'(0));
        check("rst_ovf",    EW'(overflow),   EW'(0));
        check("rst_drop",   EW'(drop_count), EW'(0));
        check("rst_state",  EW'(cur_state),  EW'(0));
        check("rst_halted", EW'(halted),     EW'(0));

        n_rst = 1'b1;
        guard = 0;
        while (tb_ts != 32'd100 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("ts_reach_100", EW'(tb_ts), EW'(100));

        // First event at timestamp 100
        send_ev(32'h0000_0016, 1'b1);
        check("ev1_valid",  EW'(log_valid),  EW'(1));
        check("ev1_status", EW'(log_status), EW'(32'h16));
        check("ev1_time",   EW'(log_time),   EW'(100));
        check("ev1_irq",    EW'(irq_out),    EW'(1));
        check("ev1_state",  EW'(cur_state),  EW'(6));
        check("ev1_halted", EW'(halted),     EW'(0));

        // Second event: board 3, code 11, halted state
        send_ev(32'h6000_00B7, 1'b1);
        check("ev2_board",  EW'(cur_board), EW'(3));
        check("ev2_code",   EW'(cur_code),  EW'(11));
        check("ev2_halted", EW'(halted),    EW'(1));
        check("ev2_count",  EW'(log_count), EW'(2));
        pulse(0);
        check("ack_irq",    EW'(irq_out),   EW'(0));
        pop_one("pop_ev1");
        pop_one("pop_ev2");
        check("drain_valid", EW'(log_valid), EW'(0));
        check("drain_count", EW'(log_count), EW'(0));

        // 17 events into a 16-deep FIFO: the last one is dropped
        for (int i = 0; i < 17; i++) begin
            w = {3'(i % 8), 25'(200 + i), 4'($urandom_range(1, 7))};
            send_ev(w, i < DEPTH);
        end
        check("ovf_count", EW'(log_count),  EW'(16));
        check("ovf_flag",  EW'(overflow),   EW'(1));
        check("ovf_drop",  EW'(drop_count), EW'(1));
        check("ovf_irq",   EW'(irq_out),    EW'(1));
        last_t = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i > 0) check("ts_incr", EW'(log_time > last_t), EW'(1));
            last_t = log_time;
            pop_one("ovf_pop");
        end
        check("ovf_empty", EW'(log_valid), EW'(0));

        pulse(1);
        check("clr_ovf",  EW'(overflow),   EW'(0));
        check("clr_drop", EW'(drop_count), EW'(0));

        // Full FIFO with push and pop in the same cycle
        for (int i = 0; i < DEPTH; i++) begin
            send_ev({3'd2, 25'(300 + i), 4'($urandom_range(1, 7))}, 1'b1);
        end
        check("full_count", EW'(log_count), EW'(16));
        begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            check("full_pop_head", {log_status, log_time}, e);
        end
        w = 32'hA000_1234;
        status_word  = w;
        ps_interrupt = 1'b1;
        log_pop      = 1'b1;
        exp_q.push_back({w, tb_ts});
        @(negedge clk);
        ps_interrupt = 1'b0;
        log_pop      = 1'b0;
        check("pp_count", EW'(log_count), EW'(16));
        check("pp_ovf",   EW'(overflow),  EW'(0));
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) pop_one("pp_pop");
        check("pp_empty", EW'(log_count), EW'(0));

        // Level held high for 50 cycles logs once
        w = 32'h2000_0553;
        status_word  = w;
        ps_interrupt = 1'b1;
        exp_q.push_back({w, tb_ts});
        repeat (50) @(negedge clk);
        ps_interrupt = 1'b0;
        @(negedge clk);
        check("hold_count", EW'(log_count), EW'(1));
        pop_one("hold_pop");

        // Event coincident with acknowledge: set wins
        pulse(0);
        check("pre_ack_irq", EW'(irq_out), EW'(0));
        w = 32'h4000_0061;
        status_word  = w;
        ps_interrupt = 1'b1;
        irq_ack      = 1'b1;
        exp_q.push_back({w, tb_ts});
        @(negedge clk);
        ps_interrupt = 1'b0;
        irq_ack      = 1'b0;
        check("ev_ack_irq", EW'(irq_out), EW'(1));
        @(negedge clk);
        pop_one("ev_ack_pop");

        // Drops, saturating increment, ovf_clr coincident with a drop
        for (int i = 0; i < DEPTH; i++) begin
            send_ev({3'd5, 25'(400 + i), 4'd3}, 1'b1);
        end
        send_ev(32'hC000_7771, 1'b0);
        check("drop1", EW'(drop_count), EW'(1));
        send_ev(32'hC000_7782, 1'b0);
        check("drop2", EW'(drop_count), EW'(2));
        status_word  = 32'hC000_7793;
        ps_interrupt = 1'b1;
        ovf_clr      = 1'b1;
        @(negedge clk);
        ps_interrupt = 1'b0;
        ovf_clr      = 1'b0;
        check("clr_drop_cnt", EW'(drop_count), EW'(1));
        check("clr_drop_ovf", EW'(overflow),   EW'(1));
        @(negedge clk);
        pulse(1);
        check("clr2_drop", EW'(drop_count), EW'(0));
        for (int i = 0; i < DEPTH; i++) pop_one("drop_pop");

        // Pop on empty has no effect
        log_pop = 1'b1;
        @(negedge clk);
        log_pop = 1'b0;
        check("empty_pop_count", EW'(log_count), EW'(0));
        check("empty_pop_valid", EW'(log_valid), EW'(0));
        check("empty_pop_ovf",   EW'(overflow),  EW'(0));

        // Reset mid-operation, interrupt already high at release
        send_ev(32'h0000_0A11, 1'b1);
        send_ev(32'h0000_0A22, 1'b1);
        n_rst        = 1'b0;
        ps_interrupt = 1'b1;
        status_word  = 32'hE000_0C44;
        @(negedge clk);
        check("midrst_count", EW'(log_count), EW'(0));
        check("midrst_irq",   EW'(irq_out),   EW'(0));
        exp_q.delete();
        n_rst = 1'b1;
        exp_q.push_back({32'hE000_0C44, tb_ts});
        @(negedge clk);
        ps_interrupt = 1'b0;
        check("rel_valid", EW'(log_valid), EW'(1));
        check("rel_time",  EW'(log_time),  EW'(0));
        pop_one("rel_pop");

`ifdef HW_STATUS_LOGGER_DEDUP_EN
        pulse(1);
        pulse(0);
        send_ev(32'h0000_0027, 1'b1);
        check("dd_irq1", EW'(irq_out), EW'(1));
        pulse(0);
        send_ev(32'h0000_0027, 1'b0);
        check("dd_count1", EW'(log_count), EW'(1));
        check("dd_irq2",   EW'(irq_out),   EW'(0));
        send_ev(32'h0000_0017, 1'b1);
        check("dd_count2", EW'(log_count), EW'(2));
        pop_one("dd_pop1");
        pop_one("dd_pop2");
`endif

        check("final_queue", EW'(exp_q.size()), EW'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
